// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side bundle for fetch_queue.
// Carries the redirect request, the BIOS/IMEM read ports and the
// instruction handshake. The master modport is the fetch queue itself;
// the slave modport is the surrounding core/memory environment.
interface fetch_queue_if #(
    parameter int BIOS_AW = 12,
    parameter int IMEM_AW = 14
);
    logic               redirect_valid;
    logic [31:0]        redirect_pc;

    logic [BIOS_AW-1:0] bios_addr;
    logic               bios_en;
    logic [31:0]        bios_dout;

    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_en;
    logic [31:0]        imem_dout;

    logic [31:0]        inst;
    logic [31:0]        inst_pc;
    logic               inst_valid;
    logic               inst_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output bios_addr, bios_en,
        input  bios_dout,
        output imem_addr, imem_en,
        input  imem_dout,
        output inst, inst_pc, inst_valid,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  bios_addr, bios_en,
        output bios_dout,
        input  imem_addr, imem_en,
        output imem_dout,
        input  inst, inst_pc, inst_valid,
        output inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue in front of BIOS / IMEM.
// Issues one-cycle-latency reads from fetch_pc whenever credit allows,
// buffers returned words with their PC in a DEPTH-entry FIFO and hands
// them to the decoder over a valid/ready handshake. A redirect flushes
// everything in flight and restarts fetch at the new target.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, a
// response arriving while the queue is empty is forwarded straight to
// inst in the same cycle and only enqueued if the consumer stalls.
module fetch_queue #(
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int          CW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fq_entry_t;

    // fetch state
    logic [31:0]            fetch_pc;
    logic                   issue;
    logic                   sel_bios;
    logic [CW+1:0]          credit_used;

    // single outstanding read: response arrives the cycle after issue
    logic                   rsp_vld;
    logic                   rsp_bios;
    logic [31:0]            rsp_pc;
    logic                   rsp_live;
    fq_entry_t              rsp_entry;

    // queue storage and control
    fq_entry_t [DEPTH-1:0]  q_mem;
    logic [CW-1:0]          wr_ptr;
    logic [CW-1:0]          rd_ptr;
    logic [CW:0]            count;
    logic                   q_empty;
    fq_entry_t              head;
    logic                   byp;
    logic                   enq;
    logic                   deq;

    // output staging
    logic                   out_valid;
    logic [31:0]            out_inst;
    logic [31:0]            out_pc;

    // redirect targets are word aligned; the low bits are dropped
    logic                   unused_pc_lsb;
    assign unused_pc_lsb = ^bus.redirect_pc[1:0];

    assign sel_bios    = fetch_pc[30];
    assign credit_used = {1'b0, count} + {{(CW+1){1'b0}}, rsp_vld};
    // Reads stop while a redirect is pending so nothing issued from the
    // old stream can land after the flush.
    assign issue       = rst_n & ~bus.redirect_valid
                       & (credit_used < (CW+2)'(DEPTH));

    assign bus.bios_addr = fetch_pc[BIOS_AW+1:2];
    assign bus.imem_addr = fetch_pc[IMEM_AW+1:2];
    assign bus.bios_en   = issue & sel_bios;
    assign bus.imem_en   = issue & ~sel_bios;

    // The response is steered by the region latched at issue time, not the
    // current fetch_pc, which has already moved on.
    assign rsp_entry = {rsp_pc, (rsp_bios ? bus.bios_dout : bus.imem_dout)};
    assign rsp_live  = rsp_vld & ~bus.redirect_valid;

    assign q_empty = (count == '0);
    assign head    = q_mem[rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = rsp_live & q_empty;
`else
    assign byp = 1'b0;
`endif

    // Present queue head, else the bypassed response, else a NOP bubble.
    always_comb begin
        out_valid = 1'b0;
        out_inst  = NOP;
        out_pc    = '0;
        if (!q_empty) begin
            out_valid = 1'b1;
            out_inst  = head.word;
            out_pc    = head.pc;
        end else if (byp) begin
            out_valid = 1'b1;
            out_inst  = rsp_entry.word;
            out_pc    = rsp_entry.pc;
        end
    end

    assign bus.inst_valid = out_valid;
    assign bus.inst       = out_inst;
    assign bus.inst_pc    = out_pc;

    // A bypassed word that is accepted never touches the queue; redirect
    // overrides both enqueue and dequeue.
    assign deq = out_valid & bus.inst_ready & ~bus.redirect_valid & ~q_empty;
    assign enq = rsp_live & ~(byp & bus.inst_ready);

    // Fetch PC, in-flight tracking and queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_vld  <= 1'b0;
            rsp_bios <= 1'b0;
            rsp_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            rsp_vld  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            rsp_vld <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                rsp_pc   <= fetch_pc;
                rsp_bios <= sel_bios;
            end
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (CW+1)'(enq) - (CW+1)'(deq);
        end
    end

    // Queue storage write; contents need no reset, pointers gate visibility.
    always_ff @(posedge clk) begin
        if (rst_n && enq) q_mem[wr_ptr] <= rsp_entry;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter BIOS_AW, default 12, BIOS word-address width.
REQ-002 SHALL have parameter IMEM_AW, default 14, IMEM word-address width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-004 SHALL have parameter RESET_PC, default 32'h4000_0000, first fetch address.
REQ-005 SHALL have ports: clk input 1, sole clock; reset is synchronous and active-low.
REQ-006 SHALL have ports: rst_n input 1, synchronous active-low reset.
REQ-007 SHALL have ports: redirect_valid input 1, jump/branch redirect request.
REQ-008 SHALL have ports: redirect_pc input 32, redirect target.
REQ-009 SHALL have ports: bios_addr output BIOS_AW, bios_en output 1, bios_dout input 32.
REQ-010 SHALL have ports: imem_addr output IMEM_AW, imem_en output 1, imem_dout input 32.
REQ-011 SHALL have ports: inst output 32, inst_pc output 32, inst_valid output 1, inst_ready input 1.

Function
REQ-012 SHALL hold fetch_pc register; region select: fetch_pc[30]=1 -> BIOS, else IMEM.
REQ-013 SHALL drive bios_addr=fetch_pc[BIOS_AW+1:2], imem_addr=fetch_pc[IMEM_AW+1:2] combinationally.
REQ-014 SHALL issue a read (en high on selected memory only) in a cycle iff occupancy + in-flight < DEPTH and redirect_valid=0.
REQ-015 SHALL advance fetch_pc by 4 (mod 2^32 wrap) on each issued read.
REQ-016 SHALL treat memory dout as valid exactly one cycle after issue; in-flight count is 0 or 1.
REQ-017 SHALL write the returned word plus its PC into the queue tail in the response cycle.
REQ-018 SHALL present queue head on inst/inst_pc with inst_valid=1 whenever queue non-empty.
REQ-019 SHALL dequeue on inst_valid & inst_ready; inst/inst_pc stable while inst_valid & !inst_ready.
REQ-020 SHALL allow simultaneous enqueue and dequeue, occupancy unchanged; never overflows (credit rule REQ-014).
REQ-021 SHALL, on redirect_valid, in the same edge: clear queue, discard the response of any read issued the same or previous cycle, load fetch_pc with {redirect_pc[31:2],2'b00}.
REQ-022 SHALL give redirect priority over dequeue and enqueue; inst_valid=0 the cycle after redirect.
REQ-023 SHALL, after redirect at edge t, issue the target read in cycle t+1 and, without bypass, present inst_valid at t+3.
REQ-024 SHALL output inst=32'h0000_0013 (NOP) and inst_pc=0 whenever inst_valid=0.
REQ-025 SHALL, on back-to-back redirects, honour only the latest target; no stale instruction emerges.
REQ-026 SHALL sustain one instruction per cycle throughput once filled with inst_ready held high.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, set fetch_pc=RESET_PC, queue empty, in-flight cleared, inst_valid=0, bios_en=imem_en=0.
REQ-028 SHALL discard any read outstanding when reset asserts mid-operation; first issue occurs the cycle after rst_n rises.

Configuration
REQ-029 SHALL support macro FETCH_QUEUE_BYPASS_EN.
REQ-030 SHALL, with FETCH_QUEUE_BYPASS_EN defined, forward a response combinationally to inst when queue empty (inst_valid in response cycle), enqueueing it only if not accepted.
REQ-031 SHALL, without FETCH_QUEUE_BYPASS_EN, register every response in the queue first (issue-to-inst_valid latency 2 cycles).

Verification
REQ-032 SHALL cover: reset release, inst_ready=1, BIOS returns pc-tagged words -> inst_pc 0x4000_0000,0x4000_0004,... one per cycle, bios_en only.
REQ-033 SHALL cover: inst_ready=0 for 10 cycles -> exactly DEPTH entries held, en low, no loss; release -> in-order drain.
REQ-034 SHALL cover: redirect_valid with redirect_pc=0x1000_0102 while queue full -> queue flushed, next inst_pc 0x1000_0100 from IMEM, imem_addr=0x040.
REQ-035 SHALL cover: redirect in two consecutive cycles (targets 0x1000_0000 then 0x4000_0020) -> first delivered inst_pc 0x4000_0020.
REQ-036 SHALL cover: rst_n low one cycle with read in flight -> inst_valid=0, restart at 0x4000_0000, no stale word.
REQ-037 SHALL cover: both macro settings -> first inst_valid after reset 1 (bypass) vs 2 cycles after first issue.
